// File: rtl/color_queue.sv
// Colour queue: samples the upstream colour generator on a fixed cadence, filters out
// illegal and repeated codes, and buffers accepted colours for the game logic.
module color_queue #(
    parameter int DEPTH           = 4,
    parameter int NUM_COLORS      = 6,
    parameter int SAMPLE_INTERVAL = 4,
    parameter int NO_REPEAT       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rand_in,
    input  logic       flush,
    input  logic       pop,
    output logic       head_valid,
    output logic [2:0] head_color,
    output logic       next_valid,
    output logic [2:0] next_color,
    output logic       full,
    output logic [4:0] count,
    output logic [7:0] reject_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_INTERVAL - 1);
    localparam logic [4:0]    CNT_FULL = 5'(DEPTH);
    localparam logic [3:0]    NC       = 4'(NUM_COLORS);

    typedef enum logic [1:0] {
        CLS_IDLE,
        CLS_REJECT,
        CLS_DROP,
        CLS_ACCEPT
    } sample_cls_e;

    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          last_valid_q, last_valid_d;
    logic [2:0]    last_code_q, last_code_d;
    logic [7:0]    reject_q, reject_d;
    logic [2:0]    mem_q [DEPTH];

    sample_cls_e cls;
    logic        strobe;
    logic        pop_eff;
    logic        push;
    logic        wr_en;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count_q != 5'd0);
    assign next_valid = (count_q >= 5'd2);
    assign full       = (count_q == CNT_FULL);
    assign count      = count_q;
    assign reject_cnt = reject_q;
    assign head_color = head_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign next_color = next_valid ? mem_q[ptr_inc(rd_ptr_q)] : 3'd0;

    assign strobe  = (tmr_q == TMR_LAST);
    assign pop_eff = pop && head_valid;

    // Classification order matters: illegal, then repeat, then full-queue drop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cls = CLS_IDLE;
        if (strobe) begin
            if ({1'b0, rand_in} >= NC) begin
                cls = CLS_REJECT;
            end else if ((NO_REPEAT != 0) && last_valid_q && (rand_in == last_code_q)) begin
                cls = CLS_REJECT;
            end else if (full && !pop_eff) begin
                cls = CLS_DROP;
            end else begin
                cls = CLS_ACCEPT;
            end
        end
    end

    assign push = (cls == CLS_ACCEPT);

    always_comb begin
        tmr_d        = strobe ? '0 : tmr_q + TW'(1);
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d      = count_q + {4'd0, push} - {4'd0, pop_eff};
        last_valid_d = push ? 1'b1 : last_valid_q;
        last_code_d  = push ? rand_in : last_code_q;
        reject_d     = reject_q;
        wr_en        = push;
        if ((cls == CLS_REJECT) && (reject_q != 8'hFF)) begin
            reject_d = reject_q + 8'd1;
        end
        // A new game discards everything in flight but keeps the reject statistic.
        if (flush) begin
            tmr_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = 5'd0;
            last_valid_d = 1'b0;
            last_code_d  = last_code_q;
            reject_d     = reject_q;
            wr_en        = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 5'd0;
            last_valid_q <= 1'b0;
            last_code_q  <= 3'd0;
            reject_q     <= 8'd0;
        end else begin
            tmr_q        <= tmr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_valid_q <= last_valid_d;
            last_code_q  <= last_code_d;
            reject_q     <= reject_d;
        end
    end

    // NOTE: storage is not reset; count gating keeps stale entries off the outputs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rand_in;
        end
    end

endmodule

// File: tb/tb_color_queue.sv
// Self-checking bench for color_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_color_queue;

    localparam int DEPTH = 4;
    localparam int NC    = 6;
    localparam int SI    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rand_in = 3'd0;
    logic       flush = 1'b0;
    logic       pop = 1'b0;
    logic       head_valid, next_valid, full;
    logic [2:0] head_color, next_color;
    logic [4:0] count;
    logic [7:0] reject_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int q[$];
    int m_phase;
    int m_last;
    bit m_lv;
    int m_rej;

    color_queue #(.DEPTH(DEPTH), .NUM_COLORS(NC), .SAMPLE_INTERVAL(SI), .NO_REPEAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rand_in    (rand_in),
        .flush      (flush),
        .pop        (pop),
        .head_valid (head_valid),
        .head_color (head_color),
        .next_valid (next_valid),
        .next_color (next_color),
        .full       (full),
        .count      (count),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] dut_vec();
        return {head_valid, head_color, next_valid, next_color, full, count, reject_cnt};
    endfunction

    function automatic logic [22:0] model_vec();
        logic       hv, nv, fl;
        logic [2:0] hc, nc;
        hv = (q.size() > 0);
        nv = (q.size() > 1);
        fl = (q.size() == DEPTH);
        hc = hv ? 3'(q[0]) : 3'd0;
        nc = nv ? 3'(q[1]) : 3'd0;
        return {hv, hc, nv, nc, fl, 5'(q.size()), 8'(m_rej)};
    endfunction

    task automatic model_clear();
        q.delete();
        m_phase = 0;
        m_last  = 0;
        m_lv    = 1'b0;
        m_rej   = 0;
    endtask

    // Drive one cycle (called with clock low), update the model at the edge, return at negedge.
    task automatic step(input logic [2:0] r, input logic f, input logic p);
        bit strobe, do_pop, do_push;
        rand_in = r;
        flush   = f;
        pop     = p;
        @(posedge clk);
        if (f) begin
            q.delete();
            m_phase = 0;
            m_lv    = 1'b0;
        end else begin
            strobe  = (m_phase == SI - 1);
            m_phase = strobe ? 0 : m_phase + 1;
            do_pop  = p && (q.size() > 0);
            do_push = 1'b0;
            if (strobe) begin
                if (int'(r) >= NC || (m_lv && int'(r) == m_last)) begin
                    if (m_rej < 255) m_rej++;
                end else if (!(q.size() == DEPTH && !do_pop)) begin
                    do_push = 1'b1;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(int'(r));
                m_last = int'(r);
                m_lv   = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic group(input logic [2:0] r);
        repeat (SI) step(r, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        pop   = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 23'd0);
        end
        do_reset();
        repeat (SI - 1) step(3'd2, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++;
            $display("FAIL pre_strobe_idle: got %h expected %h", dut_vec(), 23'd0);
        end
    endtask

    task automatic test_hold_two();
        do_reset();
        group(3'd2);
        n_checks++;
        if (head_valid !== 1'b1 || head_color !== 3'd2 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL hold_first_accept: got hv=%b head=%0d cnt=%0d expected hv=1 head=2 cnt=1",
                     head_valid, head_color, count);
        end
        group(3'd2);
        n_checks++;
        if (reject_cnt !== 8'd1 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL hold_repeat_1: got rej=%0d cnt=%0d expected rej=1 cnt=1", reject_cnt, count);
        end
        group(3'd2);
        n_checks++;
        if (reject_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL hold_repeat_2: got rej=%0d expected 2", reject_cnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        group(3'd6);
        group(3'd7);
        n_checks++;
        if (count !== 5'd0 || head_valid !== 1'b0 || reject_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL illegal_codes: got cnt=%0d hv=%b rej=%0d expected cnt=0 hv=0 rej=2",
                     count, head_valid, reject_cnt);
        end
    endtask

    task automatic test_fill_and_pop_full();
        do_reset();
        group(3'd1);
        group(3'd3);
        group(3'd5);
        group(3'd0);
        n_checks++;
        if (full !== 1'b1 || count !== 5'd4 || head_color !== 3'd1 || next_color !== 3'd3
            || next_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b cnt=%0d head=%0d next=%0d expected full=1 cnt=4 head=1 next=3",
                     full, count, head_color, next_color);
        end
        group(3'd2);
        n_checks++;
        if (count !== 5'd4 || reject_cnt !== 8'd0 || head_color !== 3'd1) begin
            n_fail++;
            $display("FAIL full_drop: got cnt=%0d rej=%0d head=%0d expected cnt=4 rej=0 head=1",
                     count, reject_cnt, head_color);
        end
        repeat (SI - 1) step(3'd4, 1'b0, 1'b0);
        step(3'd4, 1'b0, 1'b1);
        n_checks++;
        if (count !== 5'd4 || full !== 1'b1 || head_color !== 3'd3 || next_color !== 3'd5) begin
            n_fail++;
            $display("FAIL pop_push_full: got cnt=%0d full=%b head=%0d next=%0d expected cnt=4 full=1 head=3 next=5",
                     count, full, head_color, next_color);
        end
        repeat (3) step(3'd4, 1'b0, 1'b1);
        n_checks++;
        if (count !== 5'd1 || head_color !== 3'd4 || next_valid !== 1'b0 || next_color !== 3'd0) begin
            n_fail++;
            $display("FAIL wrapped_tail: got cnt=%0d head=%0d nv=%b next=%0d expected cnt=1 head=4 nv=0 next=0",
                     count, head_color, next_valid, next_color);
        end
        step(3'd4, 1'b0, 1'b0);
        n_checks++;
        if (reject_cnt !== 8'd1 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL repeat_after_wrap: got rej=%0d cnt=%0d expected rej=1 cnt=1", reject_cnt, count);
        end
        repeat (2) step(3'd4, 1'b0, 1'b1);
        n_checks++;
        if (count !== 5'd0 || head_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_empty: got cnt=%0d hv=%b expected cnt=0 hv=0", count, head_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        group(3'd1);
        group(3'd2);
        group(3'd3);
        step(3'd3, 1'b1, 1'b1);
        n_checks++;
        if (count !== 5'd0 || head_valid !== 1'b0 || next_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got cnt=%0d hv=%b nv=%b expected cnt=0 hv=0 nv=0",
                     count, head_valid, next_valid);
        end
        repeat (SI - 1) step(3'd3, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_timer_restart: got cnt=%0d expected 0", count);
        end
        step(3'd3, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd1 || head_color !== 3'd3 || reject_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL flush_last_cleared: got cnt=%0d head=%0d rej=%0d expected cnt=1 head=3 rej=0",
                     count, head_color, reject_cnt);
        end
    endtask

    task automatic test_reset_midfill();
        do_reset();
        group(3'd1);
        group(3'd2);
        n_checks++;
        if (count !== 5'd2) begin
            n_fail++;
            $display("FAIL midfill_setup: got cnt=%0d expected 2", count);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), 23'd0);
        end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (SI - 1) step(3'd4, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_early: got cnt=%0d expected 0", count);
        end
        step(3'd4, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd1 || head_color !== 3'd4) begin
            n_fail++;
            $display("FAIL post_reset_accept: got cnt=%0d head=%0d expected cnt=1 head=4", count, head_color);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (255 * SI) step(3'd7, 1'b0, 1'b0);
        n_checks++;
        if (reject_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_reach: got rej=%0d expected 255", reject_cnt);
        end
        repeat (2 * SI) step(3'd7, 1'b0, 1'b0);
        n_checks++;
        if (reject_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold: got rej=%0d expected 255", reject_cnt);
        end
        step(3'd1, 1'b1, 1'b0);
        n_checks++;
        if (reject_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL flush_keeps_rej: got rej=%0d expected 255", reject_cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0] r;
        logic       f, p;
        int         pop_pct;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            pop_pct = (i < 400) ? 4 : ((i < 800) ? 40 : 15);
            r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            f = ($urandom_range(0, 99) < 2);
            p = ($urandom_range(0, 99) < pop_pct);
            step(r, f, p);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_two();
        test_illegal();
        test_fill_and_pop_full();
        test_flush();
        test_reset_midfill();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
